// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM state encoding, default bus widths and
// helpers locating the read-only ID/STATUS words after the register array.
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_WIDTH = 12;
  localparam int WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

  function automatic logic [31:0] id_offset(input int num_regs);
    return 32'(4 * num_regs);
  endfunction

  function automatic logic [31:0] status_offset(input int num_regs);
    return 32'(4 * num_regs + 4);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register array with word-aligned decode, read mux and error detection.
// Writes land only on a commit pulse for an error-free, in-range address.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = APB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  is_write,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] ctrl_out
);

  localparam int          IDX_W  = $clog2(NUM_REGS);
  localparam logic [31:0] ID_OFF = id_offset(NUM_REGS);
  localparam logic [31:0] ST_OFF = status_offset(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [31:0]           byte_addr;
  logic [IDX_W-1:0]      idx;
  logic                  in_regs;

  assign byte_addr = 32'(addr);
  assign idx       = addr[IDX_W+1:2];
  assign in_regs   = (byte_addr < ID_OFF);

  // ID and STATUS are read-only, so any write that misses the array is an error.
  assign err = (addr[1:0] != 2'b00) || (byte_addr > ST_OFF) || (is_write && !in_regs);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    rdata = '0;
    if (in_regs)                 rdata = regs[idx];
    else if (byte_addr == ID_OFF) rdata = ID_VALUE;
    else if (byte_addr == ST_OFF) rdata = status_in;
  end

  // NOTE: the array is cleared by reset because software may read any register
  // before writing it, and ctrl_out must come up at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && !err) begin
      regs[idx] <= wdata;
    end
  end

  assign ctrl_out = regs[0];

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: IDLE/WAIT/READY handshake FSM with a programmable wait
// counter in front of apb_reg_bank; prdata/pready/pslverr are registered.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_out
);

  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  apb_state_e              state, state_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   cap_addr, acc_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata, bank_rdata;
  logic                    cap_write, acc_write;
  logic                    setup, commit, bank_err;

  assign setup = psel && !penable;

  // In IDLE the bank looks at the live bus so a zero-wait transfer can load
  // prdata on the same edge that captures the setup phase.
  assign acc_addr  = (state == ST_IDLE) ? paddr  : cap_addr;
  assign acc_write = (state == ST_IDLE) ? pwrite : cap_write;
  assign commit    = (state == ST_READY) && psel && cap_write;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (setup) begin
          state_nxt    = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
          wait_cnt_nxt = WS;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else begin
          if (wait_cnt == WAIT_CNT_W'(1)) state_nxt = ST_READY;
          wait_cnt_nxt = wait_cnt - WAIT_CNT_W'(1);
        end
      end
      ST_READY: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == ST_IDLE && setup) begin
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
      end
      // Response is registered on entry to READY and cleared whenever it is left.
      if (state_nxt == ST_READY) begin
        pready  <= 1'b1;
        pslverr <= bank_err;
        prdata  <= (acc_write || bank_err) ? '0 : bank_rdata;
      end else begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end
  end

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .clk       (clk),
    .rstn      (rstn),
    .addr      (acc_addr),
    .is_write  (acc_write),
    .commit    (commit),
    .wdata     (cap_wdata),
    .status_in (status_in),
    .rdata     (bank_rdata),
    .err       (bank_err),
    .ctrl_out  (ctrl_out)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: slot 0 is a 2-wait-state slave, slot 1 a zero-wait slave;
// a vector table covers the register map, hand sequences cover the corners.
module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [11:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic [31:0] status_in [2];
  logic [31:0] ctrl_out [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_STATES(2)) dut (
    .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .status_in(status_in[0]), .ctrl_out(ctrl_out[0])
  );

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .status_in(status_in[1]), .ctrl_out(ctrl_out[1])
  );

  typedef struct {
    int          d;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input int d, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_waits);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_waits = exp_waits;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; returns just after the completing edge,
  // so a following call issues its setup phase with no idle gap.
  task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits);
    bit done = 0;
    rdata = '0; err = 1'b0; waits = 0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1; paddr[d] = ~addr; pwdata[d] = ~wdata;
    while (!done) begin
      @(negedge clk);
      if (pready[d]) begin
        rdata = prdata[d]; err = pslverr[d]; done = 1;
      end else begin
        waits++;
        check("prdata while not ready", prdata[d], 32'h0);
        if (waits > 32) begin
          n_checks++;
          $display("FAIL xfer timeout: got no pready after %0d cycles, required within 32", waits);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;

    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0;
    end
    status_in[0] = 32'h1234;
    status_in[1] = 32'h0;

    add_vec(0, 1, 12'h00C, 32'hDEADBEEF, 32'h0,        0, 2);
    add_vec(0, 0, 12'h00C, 32'h0,        32'hDEADBEEF, 0, 2);
    add_vec(0, 0, 12'h040, 32'h0,        32'hA9B00001, 0, 2);
    add_vec(0, 0, 12'h044, 32'h0,        32'h00001234, 0, 2);
    add_vec(0, 1, 12'h040, 32'hFFFFFFFF, 32'h0,        1, 2);
    add_vec(0, 0, 12'h040, 32'h0,        32'hA9B00001, 0, 2);
    add_vec(0, 0, 12'h002, 32'h0,        32'h0,        1, 2);
    add_vec(0, 0, 12'h100, 32'h0,        32'h0,        1, 2);
    add_vec(0, 1, 12'h0FC, 32'h1,        32'h0,        1, 2);
    add_vec(0, 0, 12'h00C, 32'h0,        32'hDEADBEEF, 0, 2);
    add_vec(0, 0, 12'h000, 32'h0,        32'h0,        0, 2);
    add_vec(0, 0, 12'h03C, 32'h0,        32'h0,        0, 2);
    add_vec(0, 1, 12'h03C, 32'h12345678, 32'h0,        0, 2);
    add_vec(0, 0, 12'h03C, 32'h0,        32'h12345678, 0, 2);
    add_vec(0, 1, 12'h044, 32'h0,        32'h0,        1, 2);
    add_vec(0, 0, 12'h048, 32'h0,        32'h0,        1, 2);
    add_vec(1, 1, 12'h008, 32'h11,       32'h0,        0, 0);
    add_vec(1, 0, 12'h008, 32'h0,        32'h11,       0, 0);
    add_vec(1, 0, 12'h002, 32'h0,        32'h0,        1, 0);

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset prdata",  prdata[0],  32'h0);
    check("reset pready",  32'(pready[0]),  32'h0);
    check("reset pslverr", 32'(pslverr[0]), 32'h0);
    check("reset ctrl_out", ctrl_out[0], 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d waits", i), 32'(w), 32'(vecs[i].exp_waits));
    end

    // Zero-wait back-to-back write then read of REG[0].
    apb_xfer(1, 1, 12'h000, 32'h5, rd, er, w);
    check("b2b write waits", 32'(w), 32'h0);
    check("b2b ctrl_out on completing edge", ctrl_out[1], 32'h5);
    apb_xfer(1, 0, 12'h000, 32'h0, rd, er, w);
    check("b2b read waits", 32'(w), 32'h0);
    check("b2b read data", rd, 32'h5);

    // penable without a preceding setup phase must be ignored.
    psel[1] = 1; penable[1] = 1; pwrite[1] = 1; paddr[1] = 12'h000; pwdata[1] = 32'hBAD;
    repeat (3) begin
      @(negedge clk);
      check("no-setup pready", 32'(pready[1]), 32'h0);
    end
    @(posedge clk); #1;
    psel[1] = 0; penable[1] = 0;
    @(posedge clk); #1;
    apb_xfer(1, 0, 12'h000, 32'h0, rd, er, w);
    check("no-setup REG0 intact", rd, 32'h5);

    // Abort a 2-wait write to REG[1] during its first wait cycle.
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 12'h004; pwdata[0] = 32'hAA;
    @(posedge clk); #1;
    psel[0] = 0; penable[0] = 0;
    repeat (4) begin
      @(negedge clk);
      check("abort pready", 32'(pready[0]), 32'h0);
    end
    @(posedge clk); #1;
    apb_xfer(0, 0, 12'h004, 32'h0, rd, er, w);
    check("abort REG1 unchanged", rd, 32'h0);
    check("abort next waits", 32'(w), 32'h2);
    check("abort next pslverr", 32'(er), 32'h0);

    // Reset asserted in the access phase of a write discards it and clears state.
    apb_xfer(1, 1, 12'h004, 32'h77, rd, er, w);
    apb_xfer(1, 0, 12'h004, 32'h0, rd, er, w);
    check("pre-reset REG1", rd, 32'h77);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 12'h004; pwdata[1] = 32'h99;
    @(posedge clk); #1;
    penable[1] = 1;
    #2 rstn = 1'b0;
    #1;
    check("mid-reset pready",  32'(pready[1]),  32'h0);
    check("mid-reset pslverr", 32'(pslverr[1]), 32'h0);
    check("mid-reset prdata",  prdata[1],  32'h0);
    check("mid-reset ctrl_out", ctrl_out[1], 32'h0);
    check("mid-reset ctrl_out slot0", ctrl_out[0], 32'h0);
    psel[1] = 0; penable[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1, 0, 12'h004, 32'h0, rd, er, w);
    check("post-reset REG1", rd, 32'h0);
    check("post-reset read waits", 32'(w), 32'h0);
    apb_xfer(0, 0, 12'h00C, 32'h0, rd, er, w);
    check("post-reset slot0 REG3", rd, 32'h0);
    check("post-reset slot0 waits", 32'(w), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the byte-address width.
REQ-003 Parameter NUM_REGS, default 16, SHALL set the number of read/write registers (2..64).
REQ-004 Parameter WAIT_STATES, default 2, SHALL set the number of access cycles with pready=0 (0..15).
REQ-005 Parameter ID_VALUE, default 32'hA9B0_0001, SHALL set the read-only ID register value.
REQ-006 clk  input  1  clock; every flop SHALL be clocked on the rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 psel, penable, pwrite  input  1 each  APB control from the master.
REQ-009 paddr  input  ADDR_WIDTH  byte address; pwdata  input  DATA_WIDTH  write data.
REQ-010 prdata  output  DATA_WIDTH  read data; pready  output  1; pslverr  output  1.
REQ-011 status_in  input  DATA_WIDTH  value returned by the read-only STATUS register.
REQ-012 ctrl_out  output  DATA_WIDTH  continuous copy of REG[0].

Function
REQ-013 The register map SHALL be word-aligned: REG[i] at 4*i; ID at 4*NUM_REGS; STATUS at 4*NUM_REGS+4.
REQ-014 The FSM SHALL have states IDLE, WAIT and READY; pready SHALL be 1 only in READY.
REQ-015 IDLE with psel=1 and penable=0 SHALL capture paddr/pwrite/pwdata and go to READY if WAIT_STATES=0, else to WAIT with the counter loaded to WAIT_STATES.
REQ-016 WAIT SHALL decrement the counter each cycle and go to READY when the counter equals 1.
REQ-017 The first access cycle SHALL therefore show pready=1 exactly WAIT_STATES cycles after it starts.
REQ-018 READY SHALL complete the transfer on that clock edge and return to IDLE; a setup phase in the following cycle SHALL be accepted (back-to-back, no idle gap needed).
REQ-019 A write SHALL commit to REG[i] on the completing edge; ctrl_out SHALL update on that same edge.
REQ-020 prdata SHALL be registered on entry to READY (REG[i], ID_VALUE or status_in sampled then) and SHALL be 0 whenever pready=0 or pwrite=1.
REQ-021 pslverr=1 with pready=1 SHALL flag: paddr[1:0]!=0, an address above STATUS, or a write to ID/STATUS; an erroring write SHALL change no register and an erroring read SHALL return prdata=0.
REQ-022 psel=0 observed in WAIT or READY SHALL abort to IDLE with no write committed and pready/pslverr returned to 0.
REQ-023 penable=1 in IDLE (no setup seen) SHALL be ignored.
REQ-024 pwdata/paddr changes after setup SHALL NOT affect the transfer (captured values are used).

Reset
REQ-025 rstn=0 SHALL immediately force the state to IDLE and set all REG[i], ctrl_out, prdata, pready, pslverr and the counter to 0.
REQ-026 Reset asserted mid-transfer SHALL discard the transfer; no partial write SHALL survive.
REQ-027 The first transfer after rstn deasserts SHALL behave as one from IDLE.

Structure
REQ-028 Package apb_pkg SHALL hold the state encoding, ID/STATUS offset helpers and default widths shared with the APB master.
REQ-029 The register array, address decode and error detect SHALL be in sub-module apb_reg_bank; the FSM and the wait counter SHALL be in apb_reg_slave.

Verification
REQ-030 Write REG[3]=0xDEADBEEF at 0x00C, then read 0x00C, WAIT_STATES=2 -> pready is low for 2 access cycles each time; read returns 0xDEADBEEF, pslverr=0.
REQ-031 WAIT_STATES=0: back-to-back write 0x000=0x5, then read 0x000 -> pready=1 in the first access cycle; ctrl_out=0x5 on the write's completing edge; read returns 0x5.
REQ-032 Read 0x040 (ID) and 0x044 with status_in=0x1234 -> 0xA9B00001 and 0x1234 are returned; a write to 0x040 gives pslverr=1 and ID is unchanged.
REQ-033 Read 0x002 and read 0x100 -> pslverr=1 and prdata=0; write 0x0FC=0x1 -> pslverr=1 and all registers unchanged.
REQ-034 Drop psel in the WAIT cycle of a write of 0xAA to 0x004 -> no pready, REG[1] stays 0, and the next transfer completes normally.
REQ-035 Assert rstn=0 in the access phase of a write, then read 0x004 -> the read returns 0 and all outputs are 0 during reset.
